// File: rtl/accel_pair_sequencer_if.sv
// ============================================================================
// Module      : accel_pair_sequencer_if
// Description : Control and pair-stream signals of the acceleration sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface accel_pair_sequencer_if #(
    parameter int BODY_ADDR_WIDTH = 9
);
    logic                       start;
    logic                       abort;
    logic [BODY_ADDR_WIDTH:0]   num_bodies;
    logic                       busy;
    logic                       done;
    logic                       issue_valid;
    logic [BODY_ADDR_WIDTH-1:0] addr_i;
    logic [BODY_ADDR_WIDTH-1:0] addr_j;
    logic                       out_valid;
    logic [BODY_ADDR_WIDTH-1:0] out_i;
    logic [BODY_ADDR_WIDTH-1:0] out_j;
    logic                       out_self;
    logic                       out_last_j;
    logic                       out_last;

    modport master (
        output start, abort, num_bodies,
        input  busy, done, issue_valid, addr_i, addr_j,
        input  out_valid, out_i, out_j, out_self, out_last_j, out_last
    );

    modport slave (
        input  start, abort, num_bodies,
        output busy, done, issue_valid, addr_i, addr_j,
        output out_valid, out_i, out_j, out_self, out_last_j, out_last
    );
endinterface

`default_nettype wire

// File: rtl/accel_pair_sequencer.sv
// ============================================================================
// Module      : accel_pair_sequencer
// Description : Issues all (i,j) body pairs j-fastest and delays their tags to
//               line up with the acceleration pipeline output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accel_pair_sequencer #(
    parameter int BODIES          = 512,
    parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
    parameter int PIPE_LATENCY    = 123
) (
    input  logic                  clk,
    input  logic                  rst,
    accel_pair_sequencer_if.slave bus
);

    localparam int AW = BODY_ADDR_WIDTH;
    localparam logic [AW:0] C_MAX_N = (AW+1)'(BODIES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] i;
        logic [AW-1:0] j;
        logic          self;
        logic          last_j;
        logic          last;
    } tag_t;

    state_t        state_q, state_d;
    logic [AW:0]   n_eff_q, n_eff_d;
    logic [AW-1:0] addr_i_q, addr_i_d;
    logic [AW-1:0] addr_j_q, addr_j_d;
    logic          issue_valid_q, issue_valid_d;
    logic          done_q, done_d;
    tag_t          tag_q [PIPE_LATENCY];
    tag_t          tag_d [PIPE_LATENCY];

    logic [AW:0]   w_n_minus1;
    logic          w_i_last;
    logic          w_j_last;
    tag_t          w_issue_tag;

    assign w_n_minus1 = n_eff_q - (AW+1)'(1);
    assign w_i_last   = ({1'b0, addr_i_q} == w_n_minus1);
    assign w_j_last   = ({1'b0, addr_j_q} == w_n_minus1);

    // Addresses are already zero outside ISSUE; flags need explicit gating.
    always_comb begin
        w_issue_tag        = '0;
        w_issue_tag.valid  = issue_valid_q;
        w_issue_tag.i      = addr_i_q;
        w_issue_tag.j      = addr_j_q;
        w_issue_tag.self   = issue_valid_q && (addr_i_q == addr_j_q);
        w_issue_tag.last_j = issue_valid_q && w_j_last;
        w_issue_tag.last   = issue_valid_q && w_j_last && w_i_last;
    end

    always_comb begin
        state_d       = state_q;
        n_eff_d       = n_eff_q;
        addr_i_d      = '0;
        addr_j_d      = '0;
        issue_valid_d = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.num_bodies == '0) begin
                        done_d = 1'b1;
                    end else begin
                        n_eff_d       = (bus.num_bodies > C_MAX_N) ? C_MAX_N : bus.num_bodies;
                        state_d       = ISSUE;
                        issue_valid_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (w_i_last && w_j_last) begin
                    state_d = DRAIN;
                end else begin
                    issue_valid_d = 1'b1;
                    if (w_j_last) begin
                        addr_i_d = addr_i_q + 1'b1;
                    end else begin
                        addr_i_d = addr_i_q;
                        addr_j_d = addr_j_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (tag_q[PIPE_LATENCY-1].last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.abort) begin
            state_d       = IDLE;
            addr_i_d      = '0;
            addr_j_d      = '0;
            issue_valid_d = 1'b0;
            done_d        = 1'b0;
        end
    end

    always_comb begin
        for (int k = 0; k < PIPE_LATENCY; k++) begin
            tag_d[k] = '0;
        end
        if (!bus.abort) begin
            tag_d[0] = w_issue_tag;
            for (int k = 1; k < PIPE_LATENCY; k++) begin
                tag_d[k] = tag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            n_eff_q       <= '0;
            addr_i_q      <= '0;
            addr_j_q      <= '0;
            issue_valid_q <= 1'b0;
            done_q        <= 1'b0;
            for (int k = 0; k < PIPE_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            n_eff_q       <= n_eff_d;
            addr_i_q      <= addr_i_d;
            addr_j_q      <= addr_j_d;
            issue_valid_q <= issue_valid_d;
            done_q        <= done_d;
            for (int k = 0; k < PIPE_LATENCY; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.issue_valid = issue_valid_q;
    assign bus.addr_i      = addr_i_q;
    assign bus.addr_j      = addr_j_q;
    assign bus.out_valid   = tag_q[PIPE_LATENCY-1].valid;
    assign bus.out_i       = tag_q[PIPE_LATENCY-1].i;
    assign bus.out_j       = tag_q[PIPE_LATENCY-1].j;
    assign bus.out_self    = tag_q[PIPE_LATENCY-1].self;
    assign bus.out_last_j  = tag_q[PIPE_LATENCY-1].last_j;
    assign bus.out_last    = tag_q[PIPE_LATENCY-1].last;

endmodule

`default_nettype wire

// File: tb/tb_accel_pair_sequencer.sv
// ============================================================================
// Module      : tb_accel_pair_sequencer
// Description : Self-checking bench; cycle-level expectations come from an
//               arithmetic model of the pair sweep (k-th pair = k/N, k%N).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accel_pair_sequencer;

    localparam int AW   = 3;
    localparam int NMAX = 8;
    localparam int LAT  = 4;
    localparam int NEVER = 1 << 30;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          iv;
        logic [AW-1:0] ai;
        logic [AW-1:0] aj;
        logic          ov;
        logic [AW-1:0] oi;
        logic [AW-1:0] oj;
        logic          self_f;
        logic          lastj;
        logic          last;
    } obs_t;

    typedef struct {
        int n;
        int restart_off;
        int restart_n;
        int abort_off;
        int exp_pairs;
        int exp_done_lat;
    } scen_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    int   have_run;
    int   r_s;
    int   r_n;
    int   r_ab;
    obs_t act;

    accel_pair_sequencer_if #(.BODY_ADDR_WIDTH(AW)) bus ();

    accel_pair_sequencer #(
        .BODIES          (NMAX),
        .BODY_ADDR_WIDTH (AW),
        .PIPE_LATENCY    (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample_dut();
        obs_t a;
        a.busy   = bus.busy;
        a.done   = bus.done;
        a.iv     = bus.issue_valid;
        a.ai     = bus.addr_i;
        a.aj     = bus.addr_j;
        a.ov     = bus.out_valid;
        a.oi     = bus.out_i;
        a.oj     = bus.out_j;
        a.self_f = bus.out_self;
        a.lastj  = bus.out_last_j;
        a.last   = bus.out_last;
        return a;
    endfunction

    // Expected outputs for cycle c of the most recently accepted sweep.
    function automatic obs_t model(int c);
        obs_t e;
        int   n, k, m;
        e = '0;
        if (have_run == 0 || c > r_ab) return e;
        n = r_n;
        k = c - r_s - 1;
        if (k < 0) return e;
        if (n == 0) begin
            e.done = (k == 0);
            return e;
        end
        if (k < n * n) begin
            e.iv = 1'b1;
            e.ai = AW'(k / n);
            e.aj = AW'(k % n);
        end
        m = k - LAT;
        if (m >= 0 && m < n * n) begin
            e.ov     = 1'b1;
            e.oi     = AW'(m / n);
            e.oj     = AW'(m % n);
            e.self_f = (m / n) == (m % n);
            e.lastj  = (m % n) == (n - 1);
            e.last   = (m == n * n - 1);
        end
        e.busy = (k < n * n + LAT);
        e.done = (k == n * n + LAT);
        return e;
    endfunction

    task automatic check_obs(input string nm, input obs_t a, input obs_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, a, e);
        end
    endtask

    task automatic check_int(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, a, e);
        end
    endtask

    task automatic tick(input logic st, input logic ab, input logic [AW:0] nb);
        obs_t e;
        @(posedge clk);
        cyc++;
        #1;
        bus.start      = st;
        bus.abort      = ab;
        bus.num_bodies = nb;
        @(negedge clk);
        act = sample_dut();
        e   = model(cyc);
        check_obs("cycle", act, e);
        if (ab) begin
            if (have_run != 0 && r_ab > cyc) r_ab = cyc;
        end else if (st && !e.busy) begin
            have_run = 1;
            r_s      = cyc;
            r_n      = (int'(nb) > NMAX) ? NMAX : int'(nb);
            r_ab     = NEVER;
        end
    endtask

    scen_t tbl [8];

    initial begin
        int s, pairs, dlat, off;
        logic st, ab;
        logic [AW:0] nb;

        total = 0; bad = 0; cyc = 0;
        have_run = 0; r_s = 0; r_n = 0; r_ab = NEVER;

        //           n  rst_off rst_n ab_off pairs done_lat
        tbl[0] = '{  3, -1,     0,    -1,    9,    14 };
        tbl[1] = '{  1, -1,     0,    -1,    1,    LAT + 2 };
        tbl[2] = '{  0, -1,     0,    -1,    0,    1 };
        tbl[3] = '{  3,  3,     5,    -1,    9,    14 };
        tbl[4] = '{  3, -1,     0,     4,    4,    -1 };
        tbl[5] = '{  2, -1,     0,    -1,    4,    9 };
        tbl[6] = '{ 12, -1,     0,    -1,    64,   69 };
        tbl[7] = '{  8, -1,     0,    -1,    64,   69 };

        bus.start = 1'b0; bus.abort = 1'b0; bus.num_bodies = '0;
        rst = 1'b1;
        #1;
        check_obs("reset", sample_dut(), obs_t'('0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) tick(1'b0, 1'b0, '0);

        for (int r = 0; r < 8; r++) begin
            tick(1'b1, 1'b0, (AW+1)'(tbl[r].n));
            s = cyc; pairs = 0; dlat = -1;
            for (int t = 0; t < 80; t++) begin
                off = cyc + 1 - s;
                st  = (off == tbl[r].restart_off);
                ab  = (off == tbl[r].abort_off);
                nb  = st ? (AW+1)'(tbl[r].restart_n) : (AW+1)'($urandom_range(0, 15));
                tick(st, ab, nb);
                if (act.iv) pairs++;
                if (act.done && dlat < 0) dlat = cyc - s;
            end
            check_int($sformatf("pairs_n%0d_row%0d", tbl[r].n, r), pairs, tbl[r].exp_pairs);
            check_int($sformatf("done_lat_n%0d_row%0d", tbl[r].n, r), dlat, tbl[r].exp_done_lat);
        end

        // Asynchronous reset six cycles into an N=3 sweep.
        tick(1'b1, 1'b0, 4'd3);
        repeat (5) tick(1'b0, 1'b0, '0);
        @(posedge clk);
        cyc++;
        #2 rst = 1'b1;
        #1;
        check_obs("rst_midsweep", sample_dut(), obs_t'('0));
        have_run = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) tick(1'b0, 1'b0, (AW+1)'($urandom_range(0, 15)));
        tick(1'b1, 1'b0, 4'd2);
        repeat (12) tick(1'b0, 1'b0, '0);

        for (int t = 0; t < 3000; t++) begin
            tick($urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0,
                 (AW+1)'($urandom_range(0, 12)));
        end
        repeat (LAT + 80) tick(1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
